// File: rtl/multicycle_core.sv
// multicycle_core: MIPS-style multicycle processor core with one shared ALU and
// a single unified memory port using a req/rdy handshake.
// Ports:
//   CLK, RSTn               clock (rising edge), asynchronous active-low reset
//   MemReq/MemWE/MemAddr/MemWD  memory request, write enable, word address, write data
//   MemRD/MemRdy            memory read data and completion (sampled while MemReq=1)
//   ALUDM/RFWE              register-file write data and one-cycle write strobe
//   Halt/Illegal            core stopped; stop caused by undefined opcode/funct
module multicycle_core #(
   parameter int unsigned   DWL    = 32,
   parameter int unsigned   AWL    = 16,
   parameter int unsigned   RFAWL  = 5,
   parameter logic [DWL-1:0] PC_RST = '0
) (
   input  logic           CLK,
   input  logic           RSTn,
   output logic           MemReq,
   output logic           MemWE,
   output logic [AWL-1:0] MemAddr,
   output logic [DWL-1:0] MemWD,
   input  logic [DWL-1:0] MemRD,
   input  logic           MemRdy,
   output logic [DWL-1:0] ALUDM,
   output logic           RFWE,
   output logic           Halt,
   output logic           Illegal
);

   localparam int unsigned NREG = 2**RFAWL;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_MEMADR,
      S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL
   } alu_e;

   state_e           state_q, state_d;
   logic [DWL-1:0]   pc_q, pc_d;
   logic [DWL-1:0]   ir_q, ir_d;
   logic [DWL-1:0]   a_q, a_d;
   logic [DWL-1:0]   b_q, b_d;
   logic [DWL-1:0]   alu_q, alu_d;
   logic [DWL-1:0]   mdr_q, mdr_d;
   logic             illegal_q, illegal_d;
   logic [DWL-1:0]   rf_q [NREG];

   // Instruction fields
   logic [5:0]       op, funct;
   logic [4:0]       shamt;
   logic [RFAWL-1:0] rs_a, rt_a, rd_a;
   logic [DWL-1:0]   simm, jump_tgt, rs_val, rt_val;

   assign op       = ir_q[31:26];
   assign funct    = ir_q[5:0];
   assign shamt    = ir_q[10:6];
   assign rs_a     = RFAWL'(ir_q[25:21]);
   assign rt_a     = RFAWL'(ir_q[20:16]);
   assign rd_a     = RFAWL'(ir_q[15:11]);
   assign simm     = {{(DWL-16){ir_q[15]}}, ir_q[15:0]};
   // pc_q already holds PC+1 once the instruction has been fetched
   assign jump_tgt = {pc_q[DWL-1:26], ir_q[25:0]};
   assign rs_val   = (rs_a == '0) ? '0 : rf_q[rs_a];
   assign rt_val   = (rt_a == '0) ? '0 : rf_q[rt_a];

   // Shared ALU operand/function select
   logic [DWL-1:0] alu_a, alu_b, alu_y;
   alu_e           alu_sel;

   always_comb begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sel = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            alu_a = pc_q;
            alu_b = DWL'(1);
         end
         S_EXEC: begin
            case (funct)
               FN_SUB:  alu_sel = ALU_SUB;
               FN_AND:  alu_sel = ALU_AND;
               FN_OR:   alu_sel = ALU_OR;
               FN_SLT:  alu_sel = ALU_SLT;
               FN_SLL:  alu_sel = ALU_SLL;
               default: alu_sel = ALU_ADD;
            endcase
         end
         S_ADDIEX, S_MEMADR: alu_b = simm;
         S_BRANCH: begin
            alu_a = pc_q;
            alu_b = simm;
         end
         default: ;
      endcase
   end

   // Shared ALU
   always_comb begin
      case (alu_sel)
         ALU_SUB: alu_y = alu_a - alu_b;
         ALU_AND: alu_y = alu_a & alu_b;
         ALU_OR:  alu_y = alu_a | alu_b;
         ALU_SLT: alu_y = DWL'($signed(alu_a) < $signed(alu_b));
         ALU_SLL: alu_y = alu_b << shamt;
         default: alu_y = alu_a + alu_b;
      endcase
   end

   // Next-state and datapath control
   logic             rf_we;
   logic [RFAWL-1:0] rf_waddr;
   logic [DWL-1:0]   rf_wdata;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      illegal_d = illegal_q;
      rf_we     = 1'b0;
      rf_waddr  = rt_a;
      rf_wdata  = alu_q;
      case (state_q)
         S_FETCH: if (MemRdy) begin
            ir_d    = MemRD;
            pc_d    = alu_y;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d = rs_val;
            b_d = rt_val;
            case (op)
               OP_R: begin
                  if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL}) begin
                     state_d = S_EXEC;
                  end else begin
                     illegal_d = 1'b1;
                     state_d   = S_HALT;
                  end
               end
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_HALT:      state_d = S_HALT;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_EXEC: begin
            alu_d   = alu_y;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd_a;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            alu_d   = alu_y;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMADR: begin
            alu_d   = alu_y;
            state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: if (MemRdy) begin
            mdr_d   = MemRD;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rf_we    = 1'b1;
            rf_wdata = mdr_q;
            state_d  = S_FETCH;
         end
         S_MEMWR: if (MemRdy) state_d = S_FETCH;
         S_BRANCH: begin
            if (a_q == b_q) pc_d = alu_y;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_d    = jump_tgt;
            state_d = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= S_FETCH;
         pc_q      <= PC_RST;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         illegal_q <= illegal_d;
      end
   end

   // Register file: contents survive reset; R0 is hardwired through the read mux
   always_ff @(posedge CLK) begin
      if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
   end

   // Outputs decoded from registered state. Reset comes back to FETCH, whose
   // request must still be suppressed while RSTn is low, so the request
   // strobes are gated directly by RSTn.
   logic mem_req_c;
   assign mem_req_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign MemReq    = RSTn & mem_req_c;
   assign MemWE     = RSTn & (state_q == S_MEMWR);
   assign MemAddr   = !MemReq ? '0 : (state_q == S_FETCH) ? AWL'(pc_q) : AWL'(alu_q);
   assign MemWD     = MemWE ? b_q : '0;
   assign RFWE      = rf_we;
   assign ALUDM     = rf_we ? rf_wdata : '0;
   assign Halt      = (state_q == S_HALT);
   assign Illegal   = illegal_q;

endmodule
